// File: rtl/event_timestamp_logger.sv
// Timestamps rising edges of c = a & b against a free-running counter and queues them in a show-ahead FIFO.
// Define FALL_EDGE_LOG_EN to also log falling edges of c (rd_tag = 1).
module event_timestamp_logger #(
  parameter int TS_W  = 32,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  output logic             c,
  output logic [TS_W-1:0]  ts_now,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [TS_W-1:0]  rd_data,
  output logic             rd_tag,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [TS_W:0]      mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               n;
  logic               ev;
  logic               ev_tag;
  logic               full;
  logic               pop;
  logic               accept;
  logic               drop;

  assign n = a & b;

`ifdef FALL_EDGE_LOG_EN
  assign ev     = n ^ c;
  assign ev_tag = c;
`else
  assign ev     = n & ~c;
  assign ev_tag = 1'b0;
`endif

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign full     = (count == CNT_W'(DEPTH));
  assign rd_valid = (count != '0);
  assign pop      = rd_valid & rd_ready;
  assign accept   = ev & (~full | pop);
  assign drop     = ev & full & ~pop;
  assign rd_data  = mem[rd_ptr][TS_W-1:0];
  assign rd_tag   = mem[rd_ptr][TS_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_now <= '0;
      c      <= 1'b0;
    end else begin
      ts_now <= ts_now + TS_W'(1);
      c      <= n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {ev_tag, ts_now};
  end

  // A drop in the same cycle as a clear request keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_event_timestamp_logger.sv
// Self-checking bench for event_timestamp_logger (TS_W=8, DEPTH=4): table vectors,
// directed corner sequences and random traffic against a queue-based reference model.
module tb_event_timestamp_logger;

  localparam int TS_W  = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             a = 1'b0;
  logic             b = 1'b0;
  logic             c;
  logic [TS_W-1:0]  ts_now;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [TS_W-1:0]  rd_data;
  logic             rd_tag;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             ovf_clr = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic           tag;
    logic [TS_W-1:0] ts;
  } entry_t;

  typedef struct {
    logic            a;
    logic            b;
    logic            rdy;
    logic [TS_W-1:0] exp_ts;
    logic            exp_c;
    logic            exp_valid;
    logic [TS_W-1:0] exp_data;
    logic [CNT_W-1:0] exp_count;
  } vec_t;

  entry_t          mq[$];
  logic [TS_W-1:0] mts;
  logic            mc;
  logic            movf;

  event_timestamp_logger #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .ts_now(ts_now),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_tag(rd_tag),
    .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mts  = '0;
    mc   = 1'b0;
    movf = 1'b0;
  endtask

  // Reference behaviour of one clock edge, from the sampled inputs and model state.
  task automatic modelEdge();
    logic   n;
    logic   ev;
    logic   tg;
    logic   dropped;
    entry_t e;
    n  = a & b;
    ev = n & ~mc;
    tg = 1'b0;
`ifdef FALL_EDGE_LOG_EN
    if (!n && mc) begin
      ev = 1'b1;
      tg = 1'b1;
    end
`endif
    dropped = 1'b0;
    if (rd_ready && mq.size() > 0) e = mq.pop_front();
    if (ev) begin
      if (mq.size() < DEPTH) begin
        e.tag = tg;
        e.ts  = mts;
        mq.push_back(e);
      end else begin
        dropped = 1'b1;
      end
    end
    if (dropped) movf = 1'b1;
    else if (ovf_clr) movf = 1'b0;
    mts = mts + 1'b1;
    mc  = n;
  endtask

  task automatic checkOutput();
    checkVal("c", 32'(c), 32'(mc));
    checkVal("ts_now", 32'(ts_now), 32'(mts));
    checkVal("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
    checkVal("count", 32'(count), 32'(mq.size()));
    checkVal("overflow", 32'(overflow), 32'(movf));
    if (mq.size() > 0) begin
      checkVal("rd_data", 32'(rd_data), 32'(mq[0].ts));
      checkVal("rd_tag", 32'(rd_tag), 32'(mq[0].tag));
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic ia, input logic ib, input logic irdy, input logic iclr);
    a        = ia;
    b        = ib;
    rd_ready = irdy;
    ovf_clr  = iclr;
    step();
  endtask

  task automatic doReset();
    rst = 1'b1;
    a = 1'b0; b = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
    @(posedge clk);
    #1;
    modelReset();
    checkOutput();
    rst = 1'b0;
  endtask

  // Step with the given a/b held until the model timestamp reaches target.
  task automatic waitTs(input logic [TS_W-1:0] target, input logic hold_ab, input logic rdy);
    int guard = 0;
    while (mts != target && guard < 400) begin
      applyStimulus(hold_ab, hold_ab, rdy, 1'b0);
      guard++;
    end
    if (guard >= 400) checkVal("wait_ts_timeout", 32'(mts), 32'(target));
  endtask

  task automatic pulseEvent();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  vec_t vecs[9];

  initial begin
    logic [TS_W-1:0] last;

    // Idle after reset, a single rise at ts 5, then pops including one while empty.
    vecs[0] = '{0,0,0, 8'd1, 0,0, 8'd0, 3'd0};
    vecs[1] = '{0,0,0, 8'd2, 0,0, 8'd0, 3'd0};
    vecs[2] = '{0,0,0, 8'd3, 0,0, 8'd0, 3'd0};
    vecs[3] = '{0,0,0, 8'd4, 0,0, 8'd0, 3'd0};
    vecs[4] = '{0,0,0, 8'd5, 0,0, 8'd0, 3'd0};
    vecs[5] = '{1,1,0, 8'd6, 1,1, 8'd5, 3'd1};
    vecs[6] = '{1,1,0, 8'd7, 1,1, 8'd5, 3'd1};
    vecs[7] = '{1,1,1, 8'd8, 1,0, 8'd0, 3'd0};
    vecs[8] = '{1,1,1, 8'd9, 1,0, 8'd0, 3'd0};

    doReset();
    checkVal("reset_ts_now", 32'(ts_now), 32'd0);
    checkVal("reset_count", 32'(count), 32'd0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].rdy, 1'b0);
      checkVal("tbl_ts", 32'(ts_now), 32'(vecs[i].exp_ts));
      checkVal("tbl_c", 32'(c), 32'(vecs[i].exp_c));
      checkVal("tbl_valid", 32'(rd_valid), 32'(vecs[i].exp_valid));
      checkVal("tbl_count", 32'(count), 32'(vecs[i].exp_count));
      if (vecs[i].exp_valid) begin
        checkVal("tbl_data", 32'(rd_data), 32'(vecs[i].exp_data));
        checkVal("tbl_tag", 32'(rd_tag), 32'd0);
      end
    end

    // Timestamp wrap: event sampled at the 257th edge carries ts 0.
    doReset();
    for (int i = 0; i < 256; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    pulseEvent();
    checkVal("wrap_rd_data", 32'(rd_data), 32'd0);
    checkVal("wrap_ts_now", 32'(ts_now), 32'd1);

    // Overflow: five rises with no consumer, then drain and clear.
    doReset();
    for (int t = 10; t <= 50; t += 10) begin
      waitTs(TS_W'(t), 1'b0, 1'b0);
      pulseEvent();
    end
`ifndef FALL_EDGE_LOG_EN
    checkVal("ovf_count", 32'(count), 32'd4);
    checkVal("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkVal("ovf_pop_data", 32'(rd_data), 32'((i + 1) * 10));
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    end
    checkVal("ovf_still_set", 32'(overflow), 32'd1);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("ovf_cleared", 32'(overflow), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Full FIFO with a simultaneous pop and push at ts 60.
    doReset();
    for (int t = 10; t <= 40; t += 10) begin
      waitTs(TS_W'(t), 1'b0, 1'b0);
      pulseEvent();
    end
    waitTs(8'd60, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
`ifndef FALL_EDGE_LOG_EN
    checkVal("fullpp_count", 32'(count), 32'd4);
    checkVal("fullpp_ovf", 32'(overflow), 32'd0);
    last = '0;
    for (int i = 0; i < 4; i++) begin
      last = rd_data;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    end
    checkVal("fullpp_last", 32'(last), 32'd60);
    checkVal("fullpp_empty", 32'(rd_valid), 32'd0);
`endif

    // Asynchronous reset with three entries stored and c high.
    doReset();
    for (int t = 2; t <= 6; t += 2) begin
      waitTs(TS_W'(t), 1'b0, 1'b0);
      pulseEvent();
    end
    #2 rst = 1'b1;
    #1;
    checkVal("arst_valid", 32'(rd_valid), 32'd0);
    checkVal("arst_count", 32'(count), 32'd0);
    checkVal("arst_ts", 32'(ts_now), 32'd0);
    checkVal("arst_c", 32'(c), 32'd0);
    a = 1'b0; b = 1'b0;
    @(posedge clk);
    #1;
    modelReset();
    rst = 1'b0;
    waitTs(8'd4, 1'b0, 1'b0);
    pulseEvent();
    checkVal("arst_new_ts", 32'(rd_data), 32'd4);

    // Rise sampled at ts 3, fall sampled at ts 7.
    doReset();
    waitTs(8'd3, 1'b0, 1'b0);
    waitTs(8'd7, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkVal("edge_first_ts", 32'(rd_data), 32'd3);
    checkVal("edge_first_tag", 32'(rd_tag), 32'd0);
`ifdef FALL_EDGE_LOG_EN
    checkVal("edge_count", 32'(count), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("edge_second_ts", 32'(rd_data), 32'd7);
    checkVal("edge_second_tag", 32'(rd_tag), 32'd1);
`else
    checkVal("edge_count", 32'(count), 32'd1);
`endif

    // Random traffic against the model.
    doReset();
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
